// File: rtl/acq_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : acq_capture_ctrl
// Brief    : Arms, keeps circular pre-trigger history, captures post-trigger
//            samples, streams the record oldest-first. Option: ACQ_AUTOTRIG_EN
// Revision : 1.0
// ============================================================================
module acq_capture_ctrl #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 14,
   parameter int HOLDOFF = 16,
   parameter int AUTO_TO = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] adc_in,
   input  logic              trig_in,
   input  logic              arm,
   input  logic              auto_mode,
   input  logic [ADDR_W-1:0] pre_len,
   input  logic [ADDR_W-1:0] post_len,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              rd_last,
   output logic              busy,
   output logic [2:0]        state_out,
   output logic              trig_seen
);
   localparam int c_cw = ADDR_W + 1;
   localparam int c_hw = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [c_cw-1:0] c_depth = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_WAIT = 3'd2,
      ST_POST = 3'd3,
      ST_READ = 3'd4,
      ST_HOLD = 3'd5
   } state_t;

   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_wptr, r_taddr, r_raddr, r_p;
   logic [c_cw-1:0]   r_q, r_n, r_cnt, r_left;
   logic [c_hw-1:0]   r_hcnt;
   logic              r_auto, r_primed;
   logic [DATA_W-1:0] r_ram_q, r_rd_data;
   logic              r_rd_valid, r_rd_last;
   logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

   logic              w_wr_en, w_trig, w_auto_fire, w_pre_done, w_post_done;
   logic              w_hold_done, w_load, w_acc_last;
   logic [c_cw-1:0]   w_q_raw, w_q_lat;
   logic [ADDR_W-1:0] w_start, w_rd_addr;

   if (HOLDOFF < 1) begin : g_chk_holdoff
      $error("HOLDOFF must be at least 1");
   end
   if (AUTO_TO < 1) begin : g_chk_auto_to
      $error("AUTO_TO must be at least 1");
   end

   // A zero post length still keeps the trigger sample; clamp so the record fits the buffer.
   assign w_q_raw = (post_len == '0) ? c_cw'(1) : {1'b0, post_len};
   assign w_q_lat = ({1'b0, pre_len} + w_q_raw > c_depth) ? c_depth - {1'b0, pre_len} : w_q_raw;

   assign w_pre_done  = (r_p == '0) || (r_cnt + c_cw'(1) == {1'b0, r_p});
   assign w_post_done = (r_cnt + c_cw'(1) == r_q);
   assign w_hold_done = (r_hcnt == c_hw'(HOLDOFF - 1));
   assign w_trig      = (r_state == ST_WAIT) && (trig_in || w_auto_fire);
   assign w_load      = (r_state == ST_READ) && r_primed && (r_left != '0) && (!r_rd_valid || rd_ready);
   assign w_acc_last  = r_rd_valid && rd_ready && r_rd_last;
   assign w_start     = ((r_state == ST_WAIT) ? r_wptr : r_taddr) - r_p;
   // Advance the read address only when the output register takes the prefetched word.
   assign w_rd_addr   = w_load ? r_raddr + ADDR_W'(1) : r_raddr;

`ifdef ACQ_AUTOTRIG_EN
   localparam int c_aw = $clog2(AUTO_TO + 1);
   logic [c_aw-1:0] r_acnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acnt <= '0;
      end else if (r_state != ST_WAIT) begin
         r_acnt <= '0;
      end else begin
         r_acnt <= r_acnt + c_aw'(1);
      end
   end
   assign w_auto_fire = (r_acnt == c_aw'(AUTO_TO));
`else
   assign w_auto_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_wr_en = 1'b0;
      case (r_state)
         ST_IDLE: if (arm) w_next = ST_PRE;
         ST_PRE: begin
            w_wr_en = 1'b1;
            if (w_pre_done) w_next = ST_WAIT;
         end
         ST_WAIT: begin
            w_wr_en = 1'b1;
            if (w_trig) w_next = (r_q == c_cw'(1)) ? ST_READ : ST_POST;
         end
         ST_POST: begin
            w_wr_en = 1'b1;
            if (w_post_done) w_next = ST_READ;
         end
         ST_READ: if (w_acc_last) w_next = ST_HOLD;
         ST_HOLD: if (w_hold_done) w_next = r_auto ? ST_PRE : ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wptr] <= adc_in;
      r_ram_q <= r_mem[w_rd_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr     <= '0;
         r_taddr    <= '0;
         r_raddr    <= '0;
         r_p        <= '0;
         r_q        <= '0;
         r_n        <= '0;
         r_cnt      <= '0;
         r_left     <= '0;
         r_hcnt     <= '0;
         r_auto     <= 1'b0;
         r_primed   <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
      end else begin
         r_primed <= 1'b0;
         r_hcnt   <= '0;
         if (w_wr_en) r_wptr <= r_wptr + ADDR_W'(1);
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (arm) begin
                  r_p    <= pre_len;
                  r_q    <= w_q_lat;
                  r_n    <= {1'b0, pre_len} + w_q_lat;
                  r_auto <= auto_mode;
               end
            end
            ST_PRE:  r_cnt <= w_pre_done ? '0 : r_cnt + c_cw'(1);
            ST_WAIT: begin
               if (w_trig) begin
                  r_taddr <= r_wptr;
                  r_cnt   <= c_cw'(1);
               end
            end
            ST_POST: r_cnt <= r_cnt + c_cw'(1);
            ST_READ: begin
               r_primed <= 1'b1;
               r_raddr  <= w_rd_addr;
               if (w_load) begin
                  r_rd_data  <= r_ram_q;
                  r_rd_valid <= 1'b1;
                  r_rd_last  <= (r_left == c_cw'(1));
                  r_left     <= r_left - c_cw'(1);
               end else if (w_acc_last) begin
                  r_rd_valid <= 1'b0;
                  r_rd_last  <= 1'b0;
               end
            end
            ST_HOLD: begin
               r_hcnt <= r_hcnt + c_hw'(1);
               r_cnt  <= '0;
            end
            default: ;
         endcase
         if (w_next == ST_READ && r_state != ST_READ) begin
            r_raddr <= w_start;
            r_left  <= r_n;
         end
      end
   end

   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign rd_last   = r_rd_last;
   assign busy      = (r_state != ST_IDLE);
   assign state_out = r_state;
   assign trig_seen = w_trig;

endmodule
`default_nettype wire

// File: tb/tb_acq_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_acq_capture_ctrl
// Brief    : Directed scoreboard bench for acq_capture_ctrl (ramp ADC input).
// Revision : 1.0
// ============================================================================
module tb_acq_capture_ctrl;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 14;
   localparam int HOLDOFF = 16;
   localparam int AUTO_TO = 50;

   logic              clk = 1'b0;
   logic              rst, trig_in, arm, auto_mode, rd_ready;
   logic [DATA_W-1:0] adc_in;
   logic [ADDR_W-1:0] pre_len, post_len;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid, rd_last, busy, trig_seen;
   logic [2:0]        state_out;

   int n_cmp = 0, n_bad = 0, cyc = 0, n_trig = 0, n_valid = 0, n_extra = 0;
   logic [DATA_W:0] sb[$];
   int st_seq[$];
   int last_st = 0;
   logic prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   logic prev_last = 1'b0;

   always #5 clk = ~clk;

   acq_capture_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLDOFF(HOLDOFF), .AUTO_TO(AUTO_TO)
   ) dut (
      .clk(clk), .rst(rst), .adc_in(adc_in), .trig_in(trig_in), .arm(arm),
      .auto_mode(auto_mode), .pre_len(pre_len), .post_len(post_len),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
      .busy(busy), .state_out(state_out), .trig_seen(trig_seen)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      adc_in = DATA_W'(cyc);
   endtask

   task automatic arm_acq(input int p, input int q, input logic am);
      pre_len   = ADDR_W'(p);
      post_len  = ADDR_W'(q);
      auto_mode = am;
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic wait_st(input int st, input int budget, input string tag);
      int i = 0;
      while (int'(state_out) != st && i < budget) begin
         step();
         i++;
      end
      chk(tag, 32'(state_out), 32'(st));
   endtask

   task automatic push_rec(input int v, input int p, input int n);
      for (int k = 0; k < n; k++) sb.push_back({(k == n - 1), DATA_W'(v - p + k)});
   endtask

   // The sample on adc_in when trig_in is raised becomes the trigger sample.
   task automatic trig_now(input int p, input int n);
      push_rec(int'(adc_in), p, n);
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
   endtask

   task automatic drain(input int budget, input logic stall, input string tag);
      int i = 0;
      logic [3:0] pat = 4'b1001;
      while ((sb.size() != 0 || rd_valid) && i < budget) begin
         rd_ready = stall ? pat[i % 4] : 1'b1;
         step();
         i++;
      end
      rd_ready = 1'b1;
      chk(tag, 32'(sb.size()), 0);
   endtask

   always @(negedge clk) begin
      logic [DATA_W:0] e;
      if (trig_seen === 1'b1) n_trig++;
      if (int'(state_out) != last_st) begin
         st_seq.push_back(int'(state_out));
         last_st = int'(state_out);
      end
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 32'(rd_valid), 1);
            chk("hold_data", 32'(rd_data), 32'(prev_data));
            chk("hold_last", 32'(rd_last), 32'(prev_last));
         end
         if (rd_valid === 1'b1) n_valid++;
         if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            if (sb.size() == 0) begin
               n_extra++;
            end else begin
               e = sb.pop_front();
               chk("rd_data", 32'(rd_data), 32'(e[DATA_W-1:0]));
               chk("rd_last", 32'(rd_last), 32'(e[DATA_W]));
            end
         end
         prev_stall = rd_valid && !rd_ready;
         prev_data  = rd_data;
         prev_last  = rd_last;
      end
   end

   initial begin
      int t0, hc, first, lastv, cnt;
      int exp_seq[6] = '{1, 2, 3, 4, 5, 0};
      rst = 1'b1; trig_in = 1'b0; arm = 1'b0; auto_mode = 1'b0; rd_ready = 1'b1;
      adc_in = '0; pre_len = '0; post_len = '0;
      repeat (3) step();
      chk("rst_state", 32'(state_out), 0);
      chk("rst_valid", 32'(rd_valid), 0);
      chk("rst_last", 32'(rd_last), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_trig_seen", 32'(trig_seen), 0);
      chk("rst_data", 32'(rd_data), 0);
      rst = 1'b0;
      step();

      // Basic record, with trigger pulses in PRE and POST that must be ignored
      st_seq.delete();
      t0 = n_trig;
      arm_acq(4, 4, 1'b0);
      chk("t1_pre", 32'(state_out), 1);
      trig_in = 1'b1; step(); trig_in = 1'b0;
      wait_st(2, 20, "t1_wait");
      for (int i = 0; i < 200 && int'(adc_in) != 100; i++) step();
      chk("t1_ramp100", 32'(adc_in), 100);
      trig_now(4, 8);
      chk("t1_post", 32'(state_out), 3);
      trig_in = 1'b1; step(); trig_in = 1'b0;
      cnt = 0; first = -1; lastv = -1;
      for (int i = 0; i < 40; i++) begin
         if (rd_valid === 1'b1) begin
            cnt++;
            if (first < 0) first = i;
            lastv = i;
         end
         step();
      end
      chk("t1_valid_cycles", 32'(cnt), 8);
      chk("t1_valid_span", 32'(lastv - first + 1), 8);
      wait_st(0, 40, "t1_idle");
      chk("t1_trig_pulses", 32'(n_trig - t0), 1);
      chk("t1_seq_len", 32'(st_seq.size()), 6);
      for (int i = 0; i < 6 && i < st_seq.size(); i++) chk("t1_seq", 32'(st_seq[i]), 32'(exp_seq[i]));

      // Full-depth record: post length clamps to 24, read address wraps
      t0 = n_trig;
      arm_acq(1000, 100, 1'b0);
      wait_st(2, 1100, "t2_wait");
      trig_now(1000, 1024);
      drain(1200, 1'b0, "t2_drain");
      wait_st(0, 40, "t2_idle");
      chk("t2_trig_pulses", 32'(n_trig - t0), 1);

      // Back-pressure with a 1,0,0,1 ready pattern
      t0 = n_trig;
      arm_acq(6, 5, 1'b0);
      wait_st(2, 20, "t3_wait");
      repeat (3) step();
      trig_now(6, 11);
      drain(200, 1'b1, "t3_drain");
      wait_st(0, 40, "t3_idle");
      chk("t3_trig_pulses", 32'(n_trig - t0), 1);

      // Auto re-arm after holdoff, ignored arm pulses, reset abort in POST
      t0 = n_trig;
      arm_acq(2, 3, 1'b1);
      wait_st(2, 20, "t5_wait");
      pre_len = 7; arm = 1'b1; step(); arm = 1'b0;
      chk("t5_arm_in_wait", 32'(state_out), 2);
      trig_now(2, 5);
      drain(100, 1'b0, "t5_drain");
      chk("t5_hold_entry", 32'(state_out), 5);
      hc = 0;
      for (int i = 0; i < 40 && state_out == 3'd5; i++) begin
         if (i == 3) arm = 1'b1;
         step();
         arm = 1'b0;
         hc++;
      end
      chk("t5_hold_len", 32'(hc), HOLDOFF);
      chk("t5_rearm", 32'(state_out), 1);
      wait_st(2, 20, "t5_wait2");
      trig_in = 1'b1; step(); trig_in = 1'b0;
      chk("t5_post2", 32'(state_out), 3);
      rst = 1'b1; step();
      chk("t5_rst_state", 32'(state_out), 0);
      chk("t5_rst_valid", 32'(rd_valid), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      rst = 1'b0;
      repeat (30) step();
      chk("t5_stay_idle", 32'(state_out), 0);
      chk("t5_trig_pulses", 32'(n_trig - t0), 2);

      // No trigger: auto-trigger when enabled, otherwise wait forever
      t0 = n_trig;
      cnt = n_valid;
      arm_acq(3, 2, 1'b0);
      wait_st(2, 20, "t6_wait");
`ifdef ACQ_AUTOTRIG_EN
      hc = 0;
      while (trig_seen !== 1'b1 && hc < 200) begin
         step();
         hc++;
      end
      chk("t6_auto_delay", 32'(hc), AUTO_TO);
      push_rec(int'(adc_in), 3, 5);
      step();
      drain(100, 1'b0, "t6_drain");
      wait_st(0, 40, "t6_idle");
      chk("t6_trig_pulses", 32'(n_trig - t0), 1);
`else
      repeat (10000) step();
      chk("t6_still_wait", 32'(state_out), 2);
      chk("t6_no_output", 32'(n_valid - cnt), 0);
      chk("t6_no_trig", 32'(n_trig - t0), 0);
      rst = 1'b1; step(); rst = 1'b0; step();
      chk("t6_idle", 32'(state_out), 0);
`endif

      chk("no_extra_samples", 32'(n_extra), 0);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/acq_capture_ctrl.md
Name: acq_capture_ctrl

Overview:
Sequences one acquisition around the existing ADC trigger block. It arms on request, keeps a circular pre-trigger history of ADC samples, and waits for the trigger pulse. It then captures a fixed number of post-trigger samples and streams the whole record, oldest first, to the UART packetiser over a valid/ready interface. It sits between the ADC sample path and trigger block on one side and the UART transmit path on the other.

Parameters:
ADDR_W, 10, log2 of buffer depth; DEPTH = 2^ADDR_W samples
DATA_W, 14, sample width
HOLDOFF, 16, idle cycles after readout before re-arm (auto mode) or return to IDLE
AUTO_TO, 1000000, auto-trigger timeout in cycles (used only with ACQ_AUTOTRIG_EN)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
adc_in  in  DATA_W  ADC sample, one per clock
trig_in  in  1  single-cycle trigger pulse from the trigger block
arm  in  1  start-acquisition pulse; honoured only in IDLE
auto_mode  in  1  1 = re-arm after HOLDOFF; 0 = single shot; sampled at arm
pre_len  in  ADDR_W  pre-trigger sample count; latched at arm
post_len  in  ADDR_W  post-trigger count, trigger sample included; latched at arm
rd_data  out  DATA_W  record sample
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts when rd_valid && rd_ready
rd_last  out  1  marks final sample of record
busy  out  1  state != IDLE
state_out  out  3  IDLE=0 PRE=1 WAIT=2 POST=3 READ=4 HOLD=5
trig_seen  out  1  one-cycle pulse on the accepted trigger

Behaviour:
- Reset (sync, active-high): state IDLE, wptr=0, counters=0; rd_data=0, rd_valid=0, rd_last=0, busy=0, trig_seen=0. Reset in any state aborts; any partial record is discarded. Buffer RAM contents are not cleared.
- Length latch at arm: P=pre_len. Q=post_len, forced to 1 if 0. If P+Q > DEPTH, Q=DEPTH-P, where P=DEPTH-1 max by width. Record length N=P+Q.
- IDLE: arm=1 -> PRE. Arm is ignored in all other states.
- PRE: writes adc_in to RAM[wptr] and increments wptr (mod DEPTH) every cycle. trig_in is ignored. After P writes -> WAIT. P=0 goes to WAIT on the next cycle.
- WAIT: keeps writing circularly. On trig_in=1, that cycle's sample is written, taddr=wptr, trig_seen=1 for one cycle, and the state goes to POST with 1 post-sample already counted. If Q=1, the state goes directly to READ.
- POST: writes until Q post-samples total (trigger sample included), then READ. trig_in is ignored.
- READ: start address S=(taddr-P) mod DEPTH. Samples are emitted in address order S..S+N-1, wrapping at DEPTH.
  - RAM read has 1-cycle latency; the output register must be prefetched so streaming sustains one sample per cycle while rd_ready=1.
  - rd_data/rd_valid/rd_last hold stable while rd_valid && !rd_ready.
  - rd_last=1 only with the Nth sample. After it is accepted, rd_valid drops the next cycle and the state goes to HOLD.
  - No ADC writes occur in READ or HOLD.
- HOLD: counts HOLDOFF cycles, then goes to PRE (auto_mode latched 1, with the same P/Q) or IDLE.
- trig_in asserted in the same cycle as the PRE->WAIT transition is ignored; triggering is eligible from the first WAIT cycle.
- Sample arithmetic: none. Samples pass through unmodified at DATA_W.

Optional Feature:
ACQ_AUTOTRIG_EN:
- Defined: a counter runs while in WAIT and clears on WAIT entry. Reaching AUTO_TO cycles without trig_in forces a trigger exactly as if trig_in=1 that cycle, with trig_seen pulsed. A real trigger in the same cycle is treated as one trigger.
- Undefined: WAIT waits indefinitely, the counter logic is absent, and AUTO_TO is unused.

Test Plan:
1. DEPTH=1024, pre_len=4, post_len=4, ramp adc_in = cycle count, trig_in pulse at ramp value 100 -> record 96,97,98,99,100,101,102,103; rd_last on 103; trig_seen one pulse.
2. pre_len=1000, post_len=100 -> Q clamped to 24; exactly 1024 samples out, ending trigger+23; read address wraps correctly.
3. rd_ready toggled 1,0,0,1 pattern during READ -> no sample lost or duplicated; data held stable during stalls; with rd_ready=1 continuously, one sample per cycle.
4. trig_in pulsed in PRE and in POST -> ignored; only the first WAIT trigger is captured; state_out sequence 1,2,3,4,5,0 in single mode.
5. auto_mode=1, HOLDOFF=16 -> state goes 5->1 exactly 16 cycles after last accepted sample; arm pulses in non-IDLE states are ignored. Assert rst mid-POST -> next cycle state_out=0, rd_valid=0, busy=0.
6. ACQ_AUTOTRIG_EN, AUTO_TO=50, no trig_in -> forced trigger 50 cycles after WAIT entry. Without the macro, no record is produced after 10000 cycles.
